// File: rtl/btn_debounce_pkg.sv
// Package: btn_debounce_pkg
//
// Board-level constants shared by the input conditioner and the logic it
// feeds, plus the helper that sizes the debounce counter.
//
// Contents:
//   CLK_HZ              board system clock frequency
//   N_BTN_DEFAULT       number of pushbuttons on the lab board
//   DEB_CYCLES_DEFAULT  stable cycles before a level change is accepted (5 ms)
//   deb_cnt_w()         counter width able to hold 0 .. cycles-1
package btn_debounce_pkg;

    localparam int CLK_HZ             = 50_000_000;
    localparam int N_BTN_DEFAULT      = 4;
    localparam int DEB_CYCLES_DEFAULT = CLK_HZ / 200;

    // The counter only ever needs to reach cycles-1, so clog2(cycles) bits
    // are enough; cycles >= 2 keeps the width at least 1.
    function automatic int deb_cnt_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// Module: debounce_cell
//
// One-bit input conditioner: 2-FF synchroniser, stability counter and
// registered edge pulses.
//
// Parameters:
//   DEB_CYCLES  consecutive disagreeing cycles needed to accept a new level
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   din    in   raw asynchronous input
//   level  out  debounced level
//   rise   out  one-cycle pulse on an accepted 0->1 change
//   fall   out  one-cycle pulse on an accepted 1->0 change
module debounce_cell
    import btn_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = deb_cnt_w(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Plain synchroniser pair, nothing between the two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    // Any agreement clears the count, so only an unbroken run of
    // DEB_CYCLES disagreements flips the level. The count stops at CNT_MAX
    // because reaching it either flips the level or is followed by a clear.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// Module: btn_debounce
//
// Input conditioner for the lab board pushbuttons and slide switch. Each
// button gets its own debounce cell; the slide switch is either debounced
// the same way (SW_DEBOUNCE_EN defined) or only synchronised (default).
// The switch never produces pulses.
//
// Parameters:
//   N_BTN       number of pushbuttons
//   DEB_CYCLES  stable cycles before a level change is accepted (>= 2)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   raw pushbuttons, active-high, asynchronous
//   sw_raw       in   raw slide switch, asynchronous
//   btn_level    out  debounced button levels
//   btn_press    out  one-cycle pulse per bit on accepted 0->1
//   btn_release  out  one-cycle pulse per bit on accepted 1->0
//   sw_level     out  conditioned switch level
//
// Build option: SW_DEBOUNCE_EN
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             sw_level
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (btn_raw[i]),
            .level (btn_level[i]),
            .rise  (btn_press[i]),
            .fall  (btn_release[i])
        );
    end

`ifdef SW_DEBOUNCE_EN
    debounce_cell #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sw_raw),
        .level (sw_level),
        .rise  (),
        .fall  ()
    );
`else
    logic sw_s1_q;
    logic sw_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q <= 1'b0;
            sw_s2_q <= 1'b0;
        end else begin
            sw_s1_q <= sw_raw;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign sw_level = sw_s2_q;
`endif

endmodule
